// File: rtl/set_associative_cache_unit.sv
// Set-associative tag/state/data store with a CPU port and a snoop port.
// Define LRU_REPLACEMENT_EN for age-based LRU; default build is round-robin.
module set_associative_cache_unit #(
   parameter int TAG_WIDTH      = 8,
   parameter int INDEX_WIDTH    = 2,
   parameter int OFFSET_WIDTH   = 2,
   parameter int DATA_WIDTH     = 32,
   parameter int NUMBER_OF_WAYS = 4,
   parameter int STATE_WIDTH    = 2,
   parameter int INVALID_STATE  = 0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [INDEX_WIDTH-1:0]  cpuIndex,
   input  logic [OFFSET_WIDTH-1:0] cpuOffset,
   input  logic [TAG_WIDTH-1:0]    cpuTagIn,
   input  logic [DATA_WIDTH-1:0]   cpuDataIn,
   input  logic [STATE_WIDTH-1:0]  cpuStateIn,
   input  logic                    cpuWriteTag,
   input  logic                    cpuWriteState,
   input  logic                    cpuWriteData,
   input  logic                    cpuAccess,
   output logic                    cpuHit,
   output logic [TAG_WIDTH-1:0]    cpuTagOut,
   output logic [STATE_WIDTH-1:0]  cpuStateOut,
   output logic [DATA_WIDTH-1:0]   cpuDataOut,
   input  logic [INDEX_WIDTH-1:0]  snoopyIndex,
   input  logic [OFFSET_WIDTH-1:0] snoopyOffset,
   input  logic [TAG_WIDTH-1:0]    snoopyTagIn,
   input  logic [STATE_WIDTH-1:0]  snoopyStateIn,
   input  logic                    snoopyWriteState,
   output logic                    snoopyHit,
   output logic [STATE_WIDTH-1:0]  snoopyStateOut,
   output logic [DATA_WIDTH-1:0]   snoopyDataOut
);

   localparam int SETS  = 1 << INDEX_WIDTH;
   localparam int WORDS = 1 << OFFSET_WIDTH;
   localparam int WAY_W =
      (NUMBER_OF_WAYS > 1) ? $clog2(NUMBER_OF_WAYS) : 1;

   typedef logic [WAY_W-1:0] way_t;

   localparam logic [STATE_WIDTH-1:0] INV =
      STATE_WIDTH'(INVALID_STATE);
   localparam way_t LAST_WAY = way_t'(NUMBER_OF_WAYS - 1);

   logic [TAG_WIDTH-1:0]   tag_q   [SETS][NUMBER_OF_WAYS];
   logic [STATE_WIDTH-1:0] state_q [SETS][NUMBER_OF_WAYS];
   logic [STATE_WIDTH-1:0] state_d [SETS][NUMBER_OF_WAYS];
   logic [DATA_WIDTH-1:0]  data_q  [SETS][NUMBER_OF_WAYS][WORDS];

   logic cpu_hit;
   way_t cpu_hit_way;
   logic inv_found;
   way_t inv_way;
   way_t policy_way;
   way_t victim_way;
   way_t cpu_sel;
   logic snoop_hit;
   way_t snoop_way;
   logic meta_upd;

   // CPU tag match: lowest matching valid way (at most one expected)
   always_comb begin
      cpu_hit     = 1'b0;
      cpu_hit_way = '0;
      for (int w = 0; w < NUMBER_OF_WAYS; w++) begin
         if (!cpu_hit &&
             state_q[cpuIndex][w] != INV &&
             tag_q[cpuIndex][w] == cpuTagIn) begin
            cpu_hit     = 1'b1;
            cpu_hit_way = way_t'(w);
         end
      end
   end

   // Prefer the lowest invalid way as victim before asking the policy
   always_comb begin
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = 0; w < NUMBER_OF_WAYS; w++) begin
         if (!inv_found && state_q[cpuIndex][w] == INV) begin
            inv_found = 1'b1;
            inv_way   = way_t'(w);
         end
      end
   end

   // Snoop tag match on its own set
   always_comb begin
      snoop_hit = 1'b0;
      snoop_way = '0;
      for (int w = 0; w < NUMBER_OF_WAYS; w++) begin
         if (!snoop_hit &&
             state_q[snoopyIndex][w] != INV &&
             tag_q[snoopyIndex][w] == snoopyTagIn) begin
            snoop_hit = 1'b1;
            snoop_way = way_t'(w);
         end
      end
   end

   assign victim_way = inv_found ? inv_way : policy_way;
   assign cpu_sel    = cpu_hit ? cpu_hit_way : victim_way;
   assign meta_upd   = cpuAccess | cpuWriteTag;

   assign cpuHit      = cpu_hit;
   assign cpuTagOut   = tag_q[cpuIndex][cpu_sel];
   assign cpuStateOut = state_q[cpuIndex][cpu_sel];
   assign cpuDataOut  = data_q[cpuIndex][cpu_sel][cpuOffset];

   assign snoopyHit      = snoop_hit;
   assign snoopyStateOut =
      snoop_hit ? state_q[snoopyIndex][snoop_way] : INV;
   assign snoopyDataOut  =
      snoop_hit ? data_q[snoopyIndex][snoop_way][snoopyOffset]
                : '0;

   // Next state: CPU write first, snoop write last so it wins a clash
   always_comb begin
      state_d = state_q;
      if (cpuWriteState)
         state_d[cpuIndex][cpu_sel] = cpuStateIn;
      if (snoopyWriteState && snoop_hit)
         state_d[snoopyIndex][snoop_way] = snoopyStateIn;
   end

   // Coherence state: reset invalidates every line
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < NUMBER_OF_WAYS; w++)
               state_q[s][w] <= INV;
      end else begin
         state_q <= state_d;
      end
   end

   // Tags survive reset; a write in the reset cycle is dropped
   always_ff @(posedge clock) begin
      if (!reset && cpuWriteTag)
         tag_q[cpuIndex][cpu_sel] <= cpuTagIn;
   end

   // Data words survive reset; a write in the reset cycle is dropped
   always_ff @(posedge clock) begin
      if (!reset && cpuWriteData)
         data_q[cpuIndex][cpu_sel][cpuOffset] <= cpuDataIn;
   end

`ifdef LRU_REPLACEMENT_EN

   way_t age_q [SETS][NUMBER_OF_WAYS];
   way_t age_d [SETS][NUMBER_OF_WAYS];
   way_t old_age;

   // Oldest way (age NUMBER_OF_WAYS-1) is the policy choice
   always_comb begin
      policy_way = '0;
      for (int w = 0; w < NUMBER_OF_WAYS; w++) begin
         if (age_q[cpuIndex][w] == LAST_WAY)
            policy_way = way_t'(w);
      end
   end

   // Touched way becomes youngest; younger ways age by one
   always_comb begin
      age_d   = age_q;
      old_age = age_q[cpuIndex][cpu_sel];
      if (meta_upd) begin
         for (int w = 0; w < NUMBER_OF_WAYS; w++) begin
            if (way_t'(w) == cpu_sel)
               age_d[cpuIndex][w] = '0;
            else if (age_q[cpuIndex][w] < old_age)
               age_d[cpuIndex][w] = age_q[cpuIndex][w] + 1'b1;
         end
      end
   end

   // Age registers: reset age equals way number
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < NUMBER_OF_WAYS; w++)
               age_q[s][w] <= way_t'(w);
      end else begin
         age_q <= age_d;
      end
   end

`else

   way_t rr_q [SETS];
   way_t rr_d [SETS];

   assign policy_way = rr_q[cpuIndex];

   // Pointer moves only when a tag is allocated on a miss
   always_comb begin
      rr_d = rr_q;
      if (meta_upd && cpuWriteTag && !cpu_hit)
         rr_d[cpuIndex] = (rr_q[cpuIndex] == LAST_WAY)
                          ? '0 : rr_q[cpuIndex] + 1'b1;
   end

   // Round-robin pointers: reset to way 0
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int s = 0; s < SETS; s++)
            rr_q[s] <= '0;
      end else begin
         rr_q <= rr_d;
      end
   end

`endif

endmodule

// File: tb/tb_set_associative_cache_unit.sv
// Self-checking bench for set_associative_cache_unit (default parameters).
// Expected victims follow LRU_REPLACEMENT_EN when it is defined.
module tb_set_associative_cache_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  cpuIndex, cpuOffset;
   logic [7:0]  cpuTagIn;
   logic [31:0] cpuDataIn;
   logic [1:0]  cpuStateIn;
   logic        cpuWriteTag, cpuWriteState;
   logic        cpuWriteData, cpuAccess;
   logic        cpuHit;
   logic [7:0]  cpuTagOut;
   logic [1:0]  cpuStateOut;
   logic [31:0] cpuDataOut;
   logic [1:0]  snoopyIndex, snoopyOffset;
   logic [7:0]  snoopyTagIn;
   logic [1:0]  snoopyStateIn;
   logic        snoopyWriteState;
   logic        snoopyHit;
   logic [1:0]  snoopyStateOut;
   logic [31:0] snoopyDataOut;

   always #5 clock = ~clock;

   set_associative_cache_unit #(
      .TAG_WIDTH(8), .INDEX_WIDTH(2), .OFFSET_WIDTH(2),
      .DATA_WIDTH(32), .NUMBER_OF_WAYS(4),
      .STATE_WIDTH(2), .INVALID_STATE(0)
   ) dut (
      .clock(clock), .reset(reset),
      .cpuIndex(cpuIndex), .cpuOffset(cpuOffset),
      .cpuTagIn(cpuTagIn), .cpuDataIn(cpuDataIn),
      .cpuStateIn(cpuStateIn),
      .cpuWriteTag(cpuWriteTag), .cpuWriteState(cpuWriteState),
      .cpuWriteData(cpuWriteData), .cpuAccess(cpuAccess),
      .cpuHit(cpuHit), .cpuTagOut(cpuTagOut),
      .cpuStateOut(cpuStateOut), .cpuDataOut(cpuDataOut),
      .snoopyIndex(snoopyIndex), .snoopyOffset(snoopyOffset),
      .snoopyTagIn(snoopyTagIn), .snoopyStateIn(snoopyStateIn),
      .snoopyWriteState(snoopyWriteState),
      .snoopyHit(snoopyHit), .snoopyStateOut(snoopyStateOut),
      .snoopyDataOut(snoopyDataOut)
   );

   typedef struct packed {
      logic        rst;
      logic [1:0]  idx;
      logic [1:0]  off;
      logic [7:0]  tag;
      logic [31:0] din;
      logic [1:0]  sin;
      logic [3:0]  strb;
      logic [1:0]  sidx;
      logic [1:0]  soff;
      logic [7:0]  stag;
      logic [1:0]  ssin;
      logic        sws;
      logic [4:0]  chk;
      logic        ehit;
      logic [7:0]  etag;
      logic [1:0]  est;
      logic [31:0] edat;
      logic        eshit;
      logic [1:0]  esst;
      logic [31:0] esdat;
   } vec_t;

   localparam logic [3:0] W_T = 4'b1000;
   localparam logic [3:0] W_S = 4'b0100;
   localparam logic [3:0] W_D = 4'b0010;
   localparam logic [3:0] ACC = 4'b0001;
   localparam logic [4:0] C_CPU = 5'b10000;
   localparam logic [4:0] C_TAG = 5'b01000;
   localparam logic [4:0] C_DAT = 5'b00100;
   localparam logic [4:0] C_SN  = 5'b00010;
   localparam logic [4:0] C_SD  = 5'b00001;
   localparam logic [4:0] C_ALL = 5'b11111;

`ifdef LRU_REPLACEMENT_EN
   localparam logic [7:0]  VT  = 8'h11;
   localparam logic [31:0] VD  = 32'h101;
   localparam logic [7:0]  RT0 = 8'h10;
`else
   localparam logic [7:0]  VT  = 8'h10;
   localparam logic [31:0] VD  = 32'h100;
   localparam logic [7:0]  RT0 = 8'h20;
`endif

   vec_t tbl[$];
   vec_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   vnum   = 0;

   task automatic check(input string n,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %h expected %h",
                  n, vnum, act, exp);
      end
   endtask

   task automatic compare();
      vec_t e;
      e = sb.pop_front();
      if (e.chk[4]) begin
         check("cpuHit", 32'(cpuHit), 32'(e.ehit));
         check("cpuStateOut", 32'(cpuStateOut), 32'(e.est));
      end
      if (e.chk[3])
         check("cpuTagOut", 32'(cpuTagOut), 32'(e.etag));
      if (e.chk[2])
         check("cpuDataOut", cpuDataOut, e.edat);
      if (e.chk[1]) begin
         check("snoopyHit", 32'(snoopyHit), 32'(e.eshit));
         check("snoopyStateOut", 32'(snoopyStateOut),
               32'(e.esst));
      end
      if (e.chk[0])
         check("snoopyDataOut", snoopyDataOut, e.esdat);
   endtask

   task automatic apply(input vec_t v);
      @(negedge clock);
      reset         = v.rst;
      cpuIndex      = v.idx;
      cpuOffset     = v.off;
      cpuTagIn      = v.tag;
      cpuDataIn     = v.din;
      cpuStateIn    = v.sin;
      {cpuWriteTag, cpuWriteState,
       cpuWriteData, cpuAccess} = v.strb;
      snoopyIndex      = v.sidx;
      snoopyOffset     = v.soff;
      snoopyTagIn      = v.stag;
      snoopyStateIn    = v.ssin;
      snoopyWriteState = v.sws;
      sb.push_back(v);
      #1;
      compare();
      vnum++;
   endtask

   initial begin
      reset = 1'b1;
      cpuIndex = '0; cpuOffset = '0; cpuTagIn = '0;
      cpuDataIn = '0; cpuStateIn = '0;
      cpuWriteTag = 1'b0; cpuWriteState = 1'b0;
      cpuWriteData = 1'b0; cpuAccess = 1'b0;
      snoopyIndex = '0; snoopyOffset = '0; snoopyTagIn = '0;
      snoopyStateIn = '0; snoopyWriteState = 1'b0;

      // reset state, first allocate
      tbl.push_back('{idx:2'd1, tag:8'h5A, sin:2'd1,
         strb:W_T|W_S, chk:C_CPU|C_SN|C_SD, default:'0});
      tbl.push_back('{idx:2'd1, tag:8'h5A, sidx:2'd1,
         stag:8'h5A, chk:C_CPU|C_TAG|C_SN, ehit:1'b1,
         est:2'd1, etag:8'h5A, eshit:1'b1, esst:2'd1,
         default:'0});
      // fill set 2
      for (int i = 0; i < 4; i++)
         tbl.push_back('{idx:2'd2, tag:8'h10 + 8'(i),
            din:32'h100 + 32'(i), sin:2'd1,
            strb:W_T|W_S|W_D, chk:C_CPU|C_SN,
            default:'0});
      tbl.push_back('{idx:2'd2, tag:8'h10, strb:ACC,
         chk:C_CPU|C_TAG|C_DAT, ehit:1'b1, est:2'd1,
         etag:8'h10, edat:32'h100, default:'0});
      tbl.push_back('{idx:2'd2, tag:8'h12, strb:ACC,
         chk:C_CPU|C_TAG|C_DAT, ehit:1'b1, est:2'd1,
         etag:8'h12, edat:32'h102, default:'0});
      // victim choice on a full set
      tbl.push_back('{idx:2'd2, tag:8'h20,
         chk:C_CPU|C_TAG|C_DAT, est:2'd1, etag:VT,
         edat:VD, default:'0});
      tbl.push_back('{idx:2'd2, tag:8'h20, sin:2'd2,
         strb:W_T|W_S, chk:C_CPU|C_TAG|C_DAT, est:2'd1,
         etag:VT, edat:VD, default:'0});
      tbl.push_back('{idx:2'd2, tag:VT, chk:C_CPU,
         est:2'd1, default:'0});
      tbl.push_back('{idx:2'd2, tag:8'h20,
         chk:C_CPU|C_TAG|C_DAT, ehit:1'b1, est:2'd2,
         etag:8'h20, edat:VD, default:'0});
      // data write and snoop read
      tbl.push_back('{idx:2'd0, off:2'd3, tag:8'h33,
         din:32'hDEADBEEF, sin:2'd1, strb:W_T|W_S|W_D,
         chk:C_CPU, default:'0});
      tbl.push_back('{idx:2'd0, off:2'd3, tag:8'h33,
         soff:2'd3, stag:8'h33, chk:C_ALL, ehit:1'b1,
         est:2'd1, etag:8'h33, edat:32'hDEADBEEF,
         eshit:1'b1, esst:2'd1, esdat:32'hDEADBEEF,
         default:'0});
      tbl.push_back('{soff:2'd3, stag:8'h34,
         chk:C_SN|C_SD, default:'0});
      // CPU and snoop state write collide
      tbl.push_back('{idx:2'd0, tag:8'h33, sin:2'd2,
         strb:W_S, stag:8'h33, ssin:2'd3, sws:1'b1,
         chk:C_CPU|C_SN, ehit:1'b1, est:2'd1,
         eshit:1'b1, esst:2'd1, default:'0});
      tbl.push_back('{idx:2'd0, off:2'd3, tag:8'h33,
         soff:2'd3, stag:8'h33, chk:C_ALL, ehit:1'b1,
         est:2'd3, etag:8'h33, edat:32'hDEADBEEF,
         eshit:1'b1, esst:2'd3, esdat:32'hDEADBEEF,
         default:'0});
      // snoop write on miss is ignored
      tbl.push_back('{idx:2'd2, tag:8'h20, stag:8'h77,
         ssin:2'd2, sws:1'b1, chk:C_CPU|C_SN|C_SD,
         ehit:1'b1, est:2'd2, default:'0});
      tbl.push_back('{idx:2'd0, tag:8'h33, stag:8'h33,
         chk:C_CPU|C_SN, ehit:1'b1, est:2'd3,
         eshit:1'b1, esst:2'd3, default:'0});
      tbl.push_back('{idx:2'd2, tag:8'h13, sidx:2'd2,
         stag:8'h12, chk:C_ALL, ehit:1'b1, est:2'd1,
         etag:8'h13, edat:32'h103, eshit:1'b1,
         esst:2'd1, esdat:32'h102, default:'0});
      tbl.push_back('{idx:2'd1, tag:8'h5A, chk:C_CPU,
         ehit:1'b1, est:2'd1, default:'0});

      apply('{rst:1'b1, default:'0});
      apply('{rst:1'b1, default:'0});
      foreach (tbl[i]) apply(tbl[i]);

      // reset coincident with writes: writes dropped
      apply('{rst:1'b1, idx:2'd0, off:2'd3, tag:8'h33,
         din:32'h12345678, sin:2'd2,
         strb:W_T|W_S|W_D, default:'0});
      apply('{idx:2'd0, off:2'd3, tag:8'h33, soff:2'd3,
         stag:8'h33, chk:C_ALL, etag:8'h33,
         edat:32'hDEADBEEF, default:'0});
      apply('{idx:2'd2, tag:8'h20,
         chk:C_CPU|C_TAG|C_DAT, etag:RT0,
         edat:32'h100, default:'0});
      // replacement metadata restarted: refill picks way 0
      for (int i = 0; i < 4; i++)
         apply('{idx:2'd2, tag:8'h40 + 8'(i),
            din:32'h200 + 32'(i), sin:2'd1,
            strb:W_T|W_S|W_D, chk:C_CPU, default:'0});
      apply('{idx:2'd2, tag:8'h50,
         chk:C_CPU|C_TAG|C_DAT, est:2'd1, etag:8'h40,
         edat:32'h200, default:'0});

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard: %0d left, expected 0",
                  sb.size());
      end
      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
